// File: rtl/ov7670_pixel_capture.sv
// ov7670_pixel_capture
//   Capture stage on the OV7670 pixel clock. Registers VSYNC/HREF/D once,
//   pairs bytes into RGB565 pixels and emits them with pixel/line addresses.
//   Only whole frames are captured: after reset or enable loss the block waits
//   for a complete VSYNC high->low before accepting pixels again.
//
// Ports
//   i_pclk         pixel clock (only clock, rising edge)
//   i_rst          asynchronous active-high reset
//   i_enable       capture enable (level)
//   i_vsync        camera VSYNC, high = vertical blank
//   i_href         camera HREF, high = active line bytes
//   i_data[7:0]    camera byte bus
//   o_h_addr[10:0] pixel index in line (holds between strobes)
//   o_v_addr[9:0]  line index in frame (holds between strobes)
//   o_valid        one-cycle pixel strobe
//   o_pixel_data   RGB565 pixel
//   o_frame_start  pulse on VSYNC fall entering CAPTURE
//   o_frame_done   pulse on VSYNC rise leaving CAPTURE
//   o_line_err     pulse at line end if the line was malformed
//
// state   | meaning
// SYNC    | after reset/disable; wait for VSYNC high so no mid-frame start
// VBLANK  | in vertical blank; VSYNC fall starts a frame
// CAPTURE | frame active; assemble bytes, count pixels/lines

module ov7670_pixel_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter bit HI_FIRST = 1'b1
) (
    input  logic        i_pclk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_vsync,
    input  logic        i_href,
    input  logic [7:0]  i_data,
    output logic [10:0] o_h_addr,
    output logic [9:0]  o_v_addr,
    output logic        o_valid,
    output logic [15:0] o_pixel_data,
    output logic        o_frame_start,
    output logic        o_frame_done,
    output logic        o_line_err
);

    localparam logic [1:0] ST_SYNC    = 2'd0;
    localparam logic [1:0] ST_VBLANK  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);

    logic [1:0]  state;
    logic        s1_vsync, s1_href, s2_vsync, s2_href;
    logic [7:0]  s1_data;
    logic [7:0]  byte0;
    logic        phase;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        pend_valid;
    logic [15:0] pend_pixel;
    logic [10:0] pend_h;
    logic [9:0]  pend_v;

    logic vsync_fall, vsync_rise, line_end, take_byte;

    assign vsync_fall = s2_vsync & ~s1_vsync;
    assign vsync_rise = ~s2_vsync & s1_vsync;
    // VSYNC rising while HREF is still high closes the open line as well.
    assign line_end   = s2_href & (~s1_href | vsync_rise);
    assign take_byte  = s1_href & ~vsync_rise;

    always_ff @(posedge i_pclk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_SYNC;
            s1_vsync      <= 1'b0;
            s1_href       <= 1'b0;
            s1_data       <= 8'h00;
            s2_vsync      <= 1'b0;
            s2_href       <= 1'b0;
            byte0         <= 8'h00;
            phase         <= 1'b0;
            h_cnt         <= 11'd0;
            v_cnt         <= 10'd0;
            pend_valid    <= 1'b0;
            pend_pixel    <= 16'h0000;
            pend_h        <= 11'd0;
            pend_v        <= 10'd0;
            o_h_addr      <= 11'd0;
            o_v_addr      <= 10'd0;
            o_valid       <= 1'b0;
            o_pixel_data  <= 16'h0000;
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;
            o_line_err    <= 1'b0;
        end else begin
            s1_vsync      <= i_vsync;
            s1_href       <= i_href;
            s1_data       <= i_data;
            s2_vsync      <= s1_vsync;
            s2_href       <= s1_href;
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;
            o_line_err    <= 1'b0;
            pend_valid    <= 1'b0;

            // Second pipeline stage: publish the pixel formed last cycle.
            o_valid <= pend_valid & i_enable;
            if (pend_valid && i_enable) begin
                o_pixel_data <= pend_pixel;
                o_h_addr     <= pend_h;
                o_v_addr     <= pend_v;
            end

            if (!i_enable) begin
                state <= ST_SYNC;
                phase <= 1'b0;
            end else begin
                case (state)
                    ST_SYNC: begin
                        if (s1_vsync) state <= ST_VBLANK;
                    end
                    ST_VBLANK: begin
                        if (vsync_fall) begin
                            state         <= ST_CAPTURE;
                            o_frame_start <= 1'b1;
                            h_cnt         <= 11'd0;
                            v_cnt         <= 10'd0;
                            phase         <= 1'b0;
                        end
                    end
                    ST_CAPTURE: begin
                        if (line_end) begin
                            o_line_err <= phase | (h_cnt != H_LIM);
                            h_cnt      <= 11'd0;
                            phase      <= 1'b0;
                            if (v_cnt != 10'h3FF) v_cnt <= v_cnt + 10'd1;
                        end else if (take_byte) begin
                            if (!phase) begin
                                byte0 <= s1_data;
                                phase <= 1'b1;
                            end else begin
                                pend_pixel <= HI_FIRST ? {byte0, s1_data} : {s1_data, byte0};
                                pend_valid <= (h_cnt < H_LIM) && (v_cnt < V_LIM);
                                pend_h     <= h_cnt;
                                pend_v     <= v_cnt;
                                phase      <= 1'b0;
                                if (h_cnt != 11'h7FF) h_cnt <= h_cnt + 11'd1;
                            end
                        end
                        if (vsync_rise) begin
                            state        <= ST_VBLANK;
                            o_frame_done <= 1'b1;
                        end
                    end
                    default: state <= ST_SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// tb_ov7670_pixel_capture
//   Directed bench for ov7670_pixel_capture with a small 4x2 frame.
//   dut uses HI_FIRST=1, dut0 uses HI_FIRST=0; both share all inputs.

module tb_ov7670_pixel_capture;

    logic        clk = 1'b0;
    logic        rst, en, vs, hr;
    logic [7:0]  d;

    logic [10:0] h_addr, h_addr0;
    logic [9:0]  v_addr, v_addr0;
    logic        valid, valid0;
    logic [15:0] pix, pix0;
    logic        fs, fs0, fd, fd0, le, le0;

    int checks = 0;
    int errors = 0;

    logic [15:0] q_pix[$];
    logic [10:0] q_h[$];
    logic [9:0]  q_v[$];
    logic [15:0] q_pix0[$];
    int n_fs = 0, n_fd = 0, n_le = 0;

    logic [7:0] lbuf[16];

    always #5 clk = ~clk;

    ov7670_pixel_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .HI_FIRST(1'b1)) dut (
        .i_pclk(clk), .i_rst(rst), .i_enable(en), .i_vsync(vs), .i_href(hr), .i_data(d),
        .o_h_addr(h_addr), .o_v_addr(v_addr), .o_valid(valid), .o_pixel_data(pix),
        .o_frame_start(fs), .o_frame_done(fd), .o_line_err(le)
    );

    ov7670_pixel_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .HI_FIRST(1'b0)) dut0 (
        .i_pclk(clk), .i_rst(rst), .i_enable(en), .i_vsync(vs), .i_href(hr), .i_data(d),
        .o_h_addr(h_addr0), .o_v_addr(v_addr0), .o_valid(valid0), .o_pixel_data(pix0),
        .o_frame_start(fs0), .o_frame_done(fd0), .o_line_err(le0)
    );

    always @(posedge clk) begin
        #1;
        if (valid) begin
            q_pix.push_back(pix);
            q_h.push_back(h_addr);
            q_v.push_back(v_addr);
        end
        if (valid0) q_pix0.push_back(pix0);
        if (fs) n_fs++;
        if (fd) n_fd++;
        if (le) n_le++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic h, input logic [7:0] b);
        @(negedge clk);
        vs = v;
        hr = h;
        d  = b;
    endtask

    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, lbuf[i]);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic fill_seq(input logic [7:0] seed);
        for (int i = 0; i < 16; i++) lbuf[i] = seed + 8'(i);
    endtask

    task automatic frame_begin();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_end();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    endtask

    int b, b0, fs_b, fd_b, le_b;

    initial begin
        rst = 1'b1; en = 1'b1; vs = 1'b0; hr = 1'b0; d = 8'h00;
        repeat (2) @(negedge clk);
        check_val("rst_valid", 32'(valid), 32'd0);
        check_val("rst_haddr", 32'(h_addr), 32'd0);
        check_val("rst_pix", 32'(pix), 32'd0);
        check_val("rst_fs", 32'(fs), 32'd0);

        // 1: no start while vsync stays low, href toggling
        rst = 1'b0;
        b = q_pix.size(); fs_b = n_fs;
        for (int i = 0; i < 12; i++) step(1'b0, 1'(i % 2), 8'(i * 7));
        step(1'b0, 1'b0, 8'h00);
        repeat (3) step(1'b0, 1'b0, 8'h00);
        check_val("t1_no_valid", 32'(q_pix.size() - b), 32'd0);
        check_val("t1_no_fs", 32'(n_fs - fs_b), 32'd0);
        frame_begin();
        check_val("t1_fs_once", 32'(n_fs - fs_b), 32'd1);

        // 2: 4x2 frame, F8 00 07 E0 pattern
        b = q_pix.size(); b0 = q_pix0.size(); fd_b = n_fd; le_b = n_le;
        lbuf[0] = 8'hF8; lbuf[1] = 8'h00; lbuf[2] = 8'h07; lbuf[3] = 8'hE0;
        lbuf[4] = 8'hF8; lbuf[5] = 8'h00; lbuf[6] = 8'h07; lbuf[7] = 8'hE0;
        send_line(8);
        send_line(8);
        frame_end();
        check_val("t2_strobes", 32'(q_pix.size() - b), 32'd8);
        check_val("t2_pix0", 32'(q_pix[b]), 32'hF800);
        check_val("t2_h0", 32'(q_h[b]), 32'd0);
        check_val("t2_v0", 32'(q_v[b]), 32'd0);
        check_val("t2_pix1", 32'(q_pix[b+1]), 32'h07E0);
        check_val("t2_h1", 32'(q_h[b+1]), 32'd1);
        check_val("t2_h7", 32'(q_h[b+7]), 32'd3);
        check_val("t2_v7", 32'(q_v[b+7]), 32'd1);
        check_val("t2_fd_once", 32'(n_fd - fd_b), 32'd1);
        check_val("t2_no_lerr", 32'(n_le - le_b), 32'd0);
        check_val("t2_lofirst_pix", 32'(q_pix0[b0]), 32'h00F8);
        check_val("t2_hold_h", 32'(h_addr), 32'd3);
        check_val("t2_hold_v", 32'(v_addr), 32'd1);

        // 3: HI_FIRST=0 pairing and two-cycle latency, short line
        frame_begin();
        b = q_pix.size(); le_b = n_le;
        step(1'b0, 1'b1, 8'h1F);
        step(1'b0, 1'b1, 8'h00);
        @(posedge clk); #1 check_val("t3_lat_k", 32'(valid0), 32'd0);
        step(1'b0, 1'b1, 8'hAA);
        @(posedge clk); #1 check_val("t3_lat_k1", 32'(valid0), 32'd0);
        step(1'b0, 1'b1, 8'h55);
        @(posedge clk); #1;
        check_val("t3_lat_k2", 32'(valid0), 32'd1);
        check_val("t3_pix", 32'(pix0), 32'h001F);
        step(1'b0, 1'b1, 8'h11);
        @(posedge clk); #1 check_val("t3_one_cycle", 32'(valid0), 32'd0);
        step(1'b0, 1'b1, 8'h22);
        repeat (3) step(1'b0, 1'b0, 8'h00);
        check_val("t3_hi_pix", 32'(q_pix[b]), 32'h1F00);
        check_val("t3_short_lerr", 32'(n_le - le_b), 32'd1);
        frame_end();

        // 4: 9-byte line, 10-byte line, out-of-range third line
        frame_begin();
        b = q_pix.size(); le_b = n_le;
        lbuf[0] = 8'h10; lbuf[1] = 8'h01; lbuf[2] = 8'h20; lbuf[3] = 8'h02;
        lbuf[4] = 8'h30; lbuf[5] = 8'h03; lbuf[6] = 8'h40; lbuf[7] = 8'h04;
        lbuf[8] = 8'h99;
        send_line(9);
        check_val("t4_odd_lerr", 32'(n_le - le_b), 32'd1);
        check_val("t4_strobes_l0", 32'(q_pix.size() - b), 32'd4);
        check_val("t4_pix3", 32'(q_pix[b+3]), 32'h4004);
        check_val("t4_h3", 32'(q_h[b+3]), 32'd3);
        fill_seq(8'h50);
        send_line(10);
        check_val("t4_long_lerr", 32'(n_le - le_b), 32'd2);
        check_val("t4_strobes_l1", 32'(q_pix.size() - b), 32'd8);
        check_val("t4_l1_h", 32'(q_h[b+4]), 32'd0);
        check_val("t4_l1_v", 32'(q_v[b+4]), 32'd1);
        check_val("t4_l1_pix", 32'(q_pix[b+4]), 32'h5051);
        send_line(8);
        check_val("t4_vlimit", 32'(q_pix.size() - b), 32'd8);
        check_val("t4_vlimit_lerr", 32'(n_le - le_b), 32'd2);
        frame_end();

        // 5: enable drop mid-line, re-enable mid-frame
        frame_begin();
        b = q_pix.size();
        step(1'b0, 1'b1, 8'hC1);
        step(1'b0, 1'b1, 8'hC2);
        step(1'b0, 1'b1, 8'hC3);
        step(1'b0, 1'b1, 8'hC4);
        en = 1'b0;
        @(posedge clk); #1 check_val("t5_valid_off", 32'(valid), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'hD0);
        repeat (3) step(1'b0, 1'b0, 8'h00);
        en = 1'b1;
        fill_seq(8'h60);
        send_line(8);
        fd_b = n_fd;
        frame_end();
        check_val("t5_no_strobes", 32'(q_pix.size() - b), 32'd0);
        check_val("t5_no_fd", 32'(n_fd - fd_b), 32'd0);
        fs_b = n_fs;
        frame_begin();
        send_line(8);
        check_val("t5_resume_fs", 32'(n_fs - fs_b), 32'd1);
        check_val("t5_resume_cnt", 32'(q_pix.size() - b), 32'd4);
        check_val("t5_resume_pix", 32'(q_pix[b]), 32'h6061);
        frame_end();

        // 6: async reset mid-line
        frame_begin();
        fill_seq(8'h21);
        send_line(8);
        check_val("t6_pre_h", 32'(h_addr), 32'd3);
        step(1'b0, 1'b1, 8'hE1);
        step(1'b0, 1'b1, 8'hE2);
        #2 rst = 1'b1;
        #1;
        check_val("t6_rst_h", 32'(h_addr), 32'd0);
        check_val("t6_rst_pix", 32'(pix), 32'd0);
        check_val("t6_rst_valid", 32'(valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        b = q_pix.size(); fd_b = n_fd;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'hE3);
        repeat (3) step(1'b0, 1'b0, 8'h00);
        send_line(8);
        frame_end();
        check_val("t6_no_strobes", 32'(q_pix.size() - b), 32'd0);
        check_val("t6_no_fd", 32'(n_fd - fd_b), 32'd0);
        frame_begin();
        send_line(8);
        check_val("t6_resume_cnt", 32'(q_pix.size() - b), 32'd4);
        check_val("t6_resume_pix", 32'(q_pix[b+1]), 32'h2324);
        frame_end();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
